// File: rtl/alu_pkg.sv
// alu_pkg: shared op, class and FSM state encodings for the ALU execution unit
package alu_pkg;
  typedef enum logic [2:0] {OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SLT, OP_MOD, OP_ILL} alu_op_e;
  typedef enum logic [1:0] {S_IDLE, S_ITER, S_DONE} state_e;
  localparam logic [1:0] CLS_LS = 2'b00;
  localparam logic [1:0] CLS_BR = 2'b01;
  localparam logic [1:0] CLS_R  = 2'b10;
  localparam logic [1:0] CLS_I  = 2'b11;
endpackage

// File: rtl/alu_op_decode.sv
// alu_op_decode: maps aluop/funct/opcode onto the internal op encoding
module alu_op_decode
  import alu_pkg::*;
(
  input  logic [1:0] aluop,
  input  logic [3:0] funct,
  input  logic [2:0] opcode,
  output alu_op_e    op
);
  alu_op_e r_op, i_op;
  assign r_op = funct == 4'b0000 ? OP_ADD :
                funct == 4'b0001 ? OP_SUB :
                funct == 4'b0010 ? OP_MOD :
                funct == 4'b1101 ? OP_XOR : OP_ILL;
  assign i_op = opcode == 3'b001 ? OP_AND :
                opcode == 3'b010 ? OP_OR  :
                opcode == 3'b011 ? OP_ADD :
                opcode == 3'b100 ? OP_SLT : OP_ILL;
  assign op = aluop == CLS_LS ? OP_ADD :
              aluop == CLS_BR ? OP_SUB :
              aluop == CLS_R  ? r_op   : i_op;
endmodule

// File: rtl/alu_exec_unit.sv
// alu_exec_unit: handshaked ALU with single-cycle ops and a WIDTH-cycle restoring MOD
module alu_exec_unit
  import alu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       aluop,
  input  logic [3:0]       funct,
  input  logic [2:0]       opcode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             overflow,
  output logic             divzero,
  output logic             illegal,
  output logic             out_valid,
  input  logic             out_ready
);
  localparam int CW = $clog2(WIDTH + 1);
  alu_op_e op;
  state_e state, state_n;
  logic [WIDTH-1:0] b_r, rem, quo, rem_n, res_c, sum, diff;
  logic [WIDTH:0] t;
  logic [CW-1:0] cnt;
  logic accept, start_mod, ovf_c, ge, slt;
  alu_op_decode u_dec (.aluop(aluop), .funct(funct), .opcode(opcode), .op(op));
  assign in_ready  = !rst && (state == S_IDLE || (state == S_DONE && out_ready));
  assign out_valid = state == S_DONE;
  assign accept    = in_valid && in_ready;
  assign start_mod = op == OP_MOD && b != '0;
  assign sum       = a + b;
  assign diff      = a - b;
  assign slt       = $signed(a) < $signed(b);
  assign t         = {rem, quo[WIDTH-1]};
  assign ge        = t >= {1'b0, b_r};
  assign rem_n     = ge ? WIDTH'(t - {1'b0, b_r}) : t[WIDTH-1:0];
  always_comb begin
    res_c = op == OP_ADD ? sum :
            op == OP_SUB ? diff :
            op == OP_AND ? a & b :
            op == OP_OR  ? a | b :
            op == OP_XOR ? a ^ b :
            op == OP_SLT ? {{(WIDTH-1){1'b0}}, slt} :
            op == OP_MOD ? a : '0;
    ovf_c = op == OP_ADD ? (a[WIDTH-1] == b[WIDTH-1] && sum[WIDTH-1] != a[WIDTH-1]) :
            op == OP_SUB ? (a[WIDTH-1] != b[WIDTH-1] && diff[WIDTH-1] != a[WIDTH-1]) : 1'b0;
  end
  always_comb begin
    state_n = state;
    if (state == S_ITER && cnt == CW'(1)) state_n = S_DONE;
    if (state == S_DONE && out_ready) state_n = S_IDLE;
    if (accept) state_n = start_mod ? S_ITER : S_DONE;
  end
  always_ff @(posedge clk) state <= rst ? S_IDLE : state_n;
  always_ff @(posedge clk) begin
    if (rst) begin
      {result, zero, overflow, divzero, illegal} <= '0;
      {b_r, rem, quo} <= '0;
      cnt <= '0;
    end else if (accept) begin
      b_r <= b;
      quo <= a;
      rem <= '0;
      cnt <= start_mod ? CW'(WIDTH) : '0;
      if (!start_mod) begin
        result   <= res_c;
        zero     <= res_c == '0;
        overflow <= ovf_c;
        divzero  <= op == OP_MOD;
        illegal  <= op == OP_ILL;
      end
    end else if (state == S_ITER) begin
      rem <= rem_n;
      quo <= {quo[WIDTH-2:0], ge};
      cnt <= cnt - CW'(1);
      if (cnt == CW'(1)) {result, zero, overflow, divzero, illegal} <= {rem_n, rem_n == '0, 3'b000};
    end
  end
endmodule

// File: tb/tb_alu_exec_unit.sv
// tb_alu_exec_unit: directed checks of alu_exec_unit at WIDTH=16
module tb_alu_exec_unit;
  logic clk = 1'b0, rst = 1'b1;
  logic [1:0] aluop = '0;
  logic [3:0] funct = '0;
  logic [2:0] opcode = '0;
  logic [15:0] a = '0, b = '0, result;
  logic in_valid = 1'b0, out_ready = 1'b0;
  logic in_ready, zero, overflow, divzero, illegal, out_valid;
  int total = 0, bad = 0, lat;
  logic ir_seen, ov_seen;

  alu_exec_unit #(.WIDTH(16)) dut (
    .clk(clk), .rst(rst), .aluop(aluop), .funct(funct), .opcode(opcode), .a(a), .b(b),
    .in_valid(in_valid), .in_ready(in_ready), .result(result), .zero(zero),
    .overflow(overflow), .divzero(divzero), .illegal(illegal),
    .out_valid(out_valid), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic set_op(input logic [1:0] c, input logic [3:0] f, input logic [2:0] o,
                        input logic [15:0] x, input logic [15:0] y);
    aluop = c; funct = f; opcode = o; a = x; b = y; in_valid = 1'b1;
  endtask

  task automatic issue(input logic [1:0] c, input logic [3:0] f, input logic [2:0] o,
                       input logic [15:0] x, input logic [15:0] y);
    set_op(c, f, o, x, y);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic retire();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic wait_valid(output int l, output logic irs);
    l = 1;
    irs = 1'b0;
    while (!out_valid && l < 40) begin
      if (in_ready) irs = 1'b1;
      tick();
      l++;
    end
  endtask

  initial begin
    tick();
    tick();
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_result", result, 16'h0000);
    chk("rst_flags", {zero, overflow, divzero, illegal}, 4'b0000);
    rst = 1'b0;
    #1;
    chk("rel_in_ready", in_ready, 1);

    issue(2'b10, 4'b0000, 3'b000, 16'h7FFF, 16'h0001);
    chk("add_valid", out_valid, 1);
    chk("add_result", result, 16'h8000);
    chk("add_flags", {zero, overflow, divzero, illegal}, 4'b0100);
    retire();
    chk("add_retired", out_valid, 0);

    issue(2'b10, 4'b0010, 3'b000, 16'h0064, 16'h0007);
    in_valid = 1'b1; aluop = 2'b10; funct = 4'b0000; a = 16'hFFFF; b = 16'hFFFF;
    wait_valid(lat, ir_seen);
    in_valid = 1'b0;
    chk("mod_latency", lat, 17);
    chk("mod_in_ready_iter", ir_seen, 0);
    chk("mod_result", result, 16'h0002);
    chk("mod_flags", {zero, overflow, divzero, illegal}, 4'b0000);
    retire();

    issue(2'b10, 4'b0010, 3'b000, 16'h1234, 16'h0000);
    chk("div0_valid", out_valid, 1);
    chk("div0_result", result, 16'h1234);
    chk("div0_flags", {zero, overflow, divzero, illegal}, 4'b0010);
    retire();

    issue(2'b11, 4'b0000, 3'b100, 16'hFFFF, 16'h0001);
    chk("slt_result", result, 16'h0001);
    retire();
    issue(2'b11, 4'b0000, 3'b111, 16'h1111, 16'h2222);
    chk("ill_result", result, 16'h0000);
    chk("ill_flags", {zero, overflow, divzero, illegal}, 4'b1001);
    retire();

    issue(2'b11, 4'b0000, 3'b001, 16'hF0F0, 16'h3C3C);
    for (int i = 0; i < 5; i++) begin
      chk("hold_valid", out_valid, 1);
      chk("hold_result", {zero, overflow, divzero, illegal, result}, {4'b0000, 16'h3030});
      tick();
    end
    out_ready = 1'b1;
    set_op(2'b10, 4'b1101, 3'b000, 16'h00FF, 16'h0FF0);
    #1;
    chk("b2b_in_ready", in_ready, 1);
    tick();
    chk("xor_valid", out_valid, 1);
    chk("xor_result", result, 16'h0F0F);
    set_op(2'b01, 4'b0000, 3'b000, 16'h8000, 16'h0001);
    tick();
    chk("sub_result", result, 16'h7FFF);
    chk("sub_ovf", overflow, 1);
    set_op(2'b00, 4'b0000, 3'b000, 16'h0003, 16'hFFFD);
    tick();
    chk("ls_result", result, 16'h0000);
    chk("ls_flags", {zero, overflow}, 2'b10);
    set_op(2'b11, 4'b0000, 3'b010, 16'hA000, 16'h000A);
    tick();
    chk("or_result", result, 16'hA00A);
    set_op(2'b10, 4'b0001, 3'b000, 16'h0005, 16'h0007);
    tick();
    chk("sub2_result", result, 16'hFFFE);
    chk("sub2_ovf", overflow, 0);
    in_valid = 1'b0;
    tick();
    out_ready = 1'b0;
    chk("stream_idle", out_valid, 0);

    issue(2'b10, 4'b0010, 3'b000, 16'h00FF, 16'h0003);
    for (int i = 0; i < 7; i++) tick();
    chk("mid_iter_in_ready", in_ready, 0);
    rst = 1'b1;
    tick();
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_in_ready", in_ready, 0);
    rst = 1'b0;
    #1;
    chk("mid_rel_in_ready", in_ready, 1);
    chk("mid_rel_result", result, 16'h0000);
    ov_seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (out_valid) ov_seen = 1'b1;
      tick();
    end
    chk("mid_no_valid", ov_seen, 0);

    issue(2'b10, 4'b0010, 3'b000, 16'hFFFF, 16'h0010);
    wait_valid(lat, ir_seen);
    chk("mod2_latency", lat, 17);
    chk("mod2_result", result, 16'h000F);
    retire();
    issue(2'b10, 4'b0010, 3'b000, 16'h0003, 16'h0009);
    wait_valid(lat, ir_seen);
    chk("mod3_result", result, 16'h0003);
    retire();
    issue(2'b10, 4'b0010, 3'b000, 16'h0015, 16'h0007);
    wait_valid(lat, ir_seen);
    chk("mod4_result", {zero, result}, {1'b1, 16'h0000});
    retire();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
